calc_display_ctrl: RTL and testbench
====================================

# calc_display_ctrl

Display back-end for the calculator: consumes the serial digit stream the calculator emits on `data`/`pos`/`status` and drives an 8-digit multiplexed seven-segment display. Digits are collected into a shadow bank and committed to the visible bank as a whole frame, so the display never tears. The block adds leading-zero blanking, an error pattern and a busy indicator, and sits between the calculator core and the board display pins.

## Interface
Parameters:
- `SCAN_DIV`, 1000: clock cycles each digit stays selected during scanning; must be ≥ 2.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `status`  in  2  calculator status: 00 error, 01 busy, 10 ready, 11 printing.
- `data`  in  4  BCD digit from the calculator; valid when `status`=11 and `pos`∈1..8.
- `pos`  in  4  stream position; `pos`=k carries digit index k−1 (k=1 is least significant).
- `an`  out  8  digit enables, active-low; `an[i]` selects digit i, with i=0 the rightmost digit.
- `seg`  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal point, active-low; used as the busy indicator.
- `frame_done`  out  1  one-cycle pulse after each frame commit.

## Operation
- Capture:
  - When `status`=11 and `pos`∈1..7, store `data` into `shadow[pos−1]`.
  - When `pos`=8, commit in the same edge: `visible[7]<=data` and `visible[6:0]<=shadow[6:0]`.
  - `status`=11 with `pos`=0 or `pos`>8 is ignored.
- Partial frames: if `status` leaves 11 before `pos`=8 is seen, `visible` is unchanged. Shadow contents stay stale; they are overwritten by the next frame.
- Leading-zero blanking:
  - Digit i is blank if `visible[j]`=0 for all j≥i, with i≥1.
  - Digit 0 is always shown, so the value 0 displays as a single "0".
- Decoding:
  - `visible` values 10–15 decode to blank.
  - Segment patterns for 0–9 use the standard active-low codes: 0 = 1000000, 1 = 1111001, 8 = 0000000.
- Error mode:
  - Entered while the registered `status`=00.
  - Digits 3..0 show E, r, r, o, with codes 0000110, 0101111, 0101111, 0100011. Digits 7..4 are blank.
  - `visible` is preserved and shown again once `status`≠00.
- Busy mode: while the registered `status`=01, `dp` is low whenever digit 0 is selected. Digits show `visible` as normal.
- Scan state machine:
  - 8 states, one per digit index `idx` 0..7.
  - A divider counts 0..SCAN_DIV−1; on the terminal count it wraps to 0 and `idx` advances, with 7 wrapping to 0.
  - Exactly one bit of `an` is low at all times.

## Timing
- Reset values:
  - Registers: `visible` and `shadow` all 0, `idx`=0, divider 0, registered status 10.
  - Outputs: `an`=11111110, `seg`=1000000 (a "0"), `dp`=1, `frame_done`=0.
- Input registration: `status` is sampled into a register each cycle. Error/busy modes follow that register, i.e. one cycle after the input.
- Output registration: `an`, `seg` and `dp` are registered. They reflect `idx`, `visible` and mode with one cycle of latency.
- Frame latency:
  - `visible` updates on the edge that samples `pos`=8.
  - `frame_done` goes high the following cycle for exactly one cycle.
  - `seg` shows the new value one cycle after that, if the digit is selected.
- Back-to-back frames, with `pos`=8 followed immediately by `pos`=1 of the next frame, are captured without loss.
- The scan divider runs free and is unaffected by capture, commit, or mode changes.
- Reset asserted mid-frame or mid-scan returns every register to its reset value at the next edge. The partial frame is discarded.

## Test plan
- **Reset:** hold `reset` 2 cycles → `an`=11111110, `seg`=1000000, `dp`=1, `frame_done`=0. With `SCAN_DIV`=4, `an` steps through 11111101, 11111011, … every 4 cycles and wraps to 11111110 after 32 cycles.
- **Frame commit:** stream digits of 1234 with `status`=11 and `pos`=1..8, carrying `data`=4,3,2,1,0,0,0,0.
  - `frame_done` pulses once, one cycle after `pos`=8.
  - Digits 0..3 show 4,3,2,1; digits 4..7 are blank (`seg`=1111111).
- **Partial frame:** after committing 1234, send `pos`=1..5 with `data`=9, then drop `status` to 10 → display still shows 1234 and `frame_done` stays 0.
- **Zero and blanking:** commit a frame of all zeros → only digit 0 lit, with "0"; digits 1..7 blank. Commit 00000800 → digit 2 shows 8, digits 1 and 0 show 0, digits 3..7 blank.
- **Error and busy modes:**
  - `status`=00 → digits 3..0 show E, r, r, o; digits 7..4 blank.
  - Return to 10 → the previous number reappears.
  - `status`=01 → `dp`=0 only while `an`=11111110.
- **Reset mid-frame:** assert `reset` at `pos`=4 → visible bank cleared to 0 and `frame_done` not pulsed. A subsequent full frame of 56 commits correctly.

Source files
------------

// File: rtl/calc_display_ctrl_if.sv
// calc_display_ctrl_if: calculator digit stream in, multiplexed seven-segment display out
interface calc_display_ctrl_if;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;
    modport master (output status, data, pos, input an, seg, dp, frame_done);
    modport slave (input status, data, pos, output an, seg, dp, frame_done);
endinterface

// File: rtl/calc_display_ctrl.sv
// calc_display_ctrl: frames the calculator digit stream into a tear-free 8-digit scanned display
module calc_display_ctrl #(
    parameter int SCAN_DIV = 1000
) (
    input logic clock,
    input logic reset,
    calc_display_ctrl_if.slave bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    typedef enum logic [2:0] {D0, D1, D2, D3, D4, D5, D6, D7} idx_t;
    logic [1:0]    r_status;
    logic [3:0]    r_shadow [7];
    logic [3:0]    r_visible [8];
    logic [DW-1:0] r_div;
    idx_t          r_idx;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_done;
    logic          w_print;
    logic          w_store;
    logic          w_commit;
    logic [2:0]    w_slot;
    logic [7:0]    w_lit;
    logic [6:0]    w_err_seg;
    logic [6:0]    w_seg;
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction
    assign w_print  = bus.status == 2'b11;
    assign w_store  = w_print && bus.pos >= 4'd1 && bus.pos <= 4'd7;
    assign w_commit = w_print && bus.pos == 4'd8;
    assign w_slot   = 3'(bus.pos - 4'd1);
    // a digit is lit once any digit at or above it is non-zero; digit 0 always lit
    always_comb begin
        logic v_acc;
        v_acc = 1'b0;
        w_lit = 8'h01;
        for (int i = 7; i >= 1; i--) begin
            v_acc    = v_acc || r_visible[i] != 4'd0;
            w_lit[i] = v_acc;
        end
    end
    always_comb begin
        w_err_seg = r_idx == D3 ? 7'b0000110 :
                    (r_idx == D2 || r_idx == D1) ? 7'b0101111 :
                    r_idx == D0 ? 7'b0100011 : SEG_BLANK;
        w_seg = r_status == 2'b00 ? w_err_seg :
                w_lit[r_idx] ? f_seg(r_visible[r_idx]) : SEG_BLANK;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_status     <= 2'b10;
            r_div        <= '0;
            r_idx        <= D0;
            r_an         <= 8'b11111110;
            r_seg        <= 7'b1000000;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 7; i++) r_shadow[i] <= 4'd0;
            for (int i = 0; i < 8; i++) r_visible[i] <= 4'd0;
        end else begin
            r_status     <= bus.status;
            r_frame_done <= w_commit;
            if (w_store) r_shadow[w_slot] <= bus.data;
            if (w_commit) begin
                r_visible[7] <= bus.data;
                for (int i = 0; i < 7; i++) r_visible[i] <= r_shadow[i];
            end
            if (r_div == DIV_MAX) begin
                r_div <= '0;
                r_idx <= idx_t'(r_idx + 3'd1);
            end else begin
                r_div <= r_div + 1'b1;
            end
            r_an  <= ~(8'b1 << r_idx);
            r_seg <= w_seg;
            r_dp  <= !(r_status == 2'b01 && r_idx == D0);
        end
    end
    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_calc_display_ctrl.sv
// tb_calc_display_ctrl: directed frames and modes, expectations queued and checked by a scanning monitor
module tb_calc_display_ctrl;
    localparam int DIV = 4;
    localparam logic [6:0] BL = 7'b1111111, S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] SE = 7'b0000110, SR = 7'b0101111, SO = 7'b0100011;
    localparam logic [1:0] K_FRAME = 2'd0, K_SNAP = 2'd1, K_IMM = 2'd2;
    typedef struct packed {
        logic [1:0]  kind;
        logic        scan;
        logic [55:0] segs;
        logic [7:0]  dp;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    bit mon_busy = 1'b0;
    exp_t q[$];
    calc_display_ctrl_if bus();
    calc_display_ctrl #(.SCAN_DIV(DIV)) dut (.clock(clk), .reset(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction
    task automatic scan_check(input exp_t e);
        logic [7:0] seen;
        int prev, last, d;
        seen = '0;
        prev = -1;
        last = -1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 10 * DIV; c++) begin
            @(negedge clk);
            chk("an_one_low", $countones(~bus.an), 1);
            d = -1;
            for (int i = 0; i < 8; i++) if (bus.an === ~(8'b1 << i)) d = i;
            if (d < 0) continue;
            if (prev >= 0 && d != prev) begin
                chk("scan_step", d, (prev + 1) % 8);
                if (last >= 0) chk("scan_period", c - last, DIV);
                last = c;
            end
            prev = d;
            if (!seen[d]) begin
                seen[d] = 1'b1;
                chk($sformatf("seg_digit%0d", d), bus.seg, e.segs[7*d+:7]);
                chk($sformatf("dp_digit%0d", d), bus.dp, e.dp[d]);
            end
        end
        chk("scan_all_digits", seen, 8'hFF);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                if (q.size() == 0 || q[0].kind != K_FRAME) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_done_unexpected: got pulse, expected none");
                end else begin
                    mon_busy = 1'b1;
                    e = q.pop_front();
                    @(negedge clk);
                    chk("frame_done_width", bus.frame_done, 0);
                    if (e.scan) scan_check(e);
                    mon_busy = 1'b0;
                end
            end else if (q.size() != 0 && q[0].kind != K_FRAME) begin
                mon_busy = 1'b1;
                e = q.pop_front();
                if (e.kind == K_IMM) begin
                    chk("reset_an", bus.an, 8'b11111110);
                    chk("reset_seg", bus.seg, 7'b1000000);
                    chk("reset_dp", bus.dp, 1);
                    chk("reset_frame_done", bus.frame_done, 0);
                end else begin
                    scan_check(e);
                end
                mon_busy = 1'b0;
            end
        end
    end
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic put(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
        bus.status = st;
        bus.pos    = p;
        bus.data   = d;
        step();
    endtask
    task automatic send_digits(input logic [31:0] w, input int n);
        for (int k = 1; k <= n; k++) put(2'b11, 4'(k), w[4*(k-1)+:4]);
    endtask
    task automatic expect_item(input logic [1:0] k, input logic s, input logic [55:0] segs, input logic [7:0] dp);
        q.push_back(exp_t'({k, s, segs, dp}));
    endtask
    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || mon_busy) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: %0d expectations still pending after %0d cycles", q.size(), n);
            q.delete();
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.status = 2'b10;
        bus.pos    = 4'd0;
        bus.data   = 4'd0;
        rst        = 1'b1;
        step(2);
        expect_item(K_IMM, 1'b0, '0, 8'hFF);
        wait_idle();
        rst = 1'b0;
        expect_item(K_SNAP, 1'b1, {{7{BL}}, S0}, 8'hFF);
        wait_idle();
        expect_item(K_FRAME, 1'b1, {{4{BL}}, S1, S2, S3, S4}, 8'hFF);
        send_digits(32'h0000_1234, 8);
        put(2'b10, 4'd0, 4'd0);
        wait_idle();
        send_digits(32'h0009_9999, 5);
        put(2'b10, 4'd0, 4'd0);
        step(3);
        expect_item(K_SNAP, 1'b1, {{4{BL}}, S1, S2, S3, S4}, 8'hFF);
        wait_idle();
        expect_item(K_FRAME, 1'b1, {{7{BL}}, S0}, 8'hFF);
        send_digits(32'h0000_0000, 8);
        put(2'b10, 4'd0, 4'd0);
        wait_idle();
        expect_item(K_FRAME, 1'b1, {{5{BL}}, S8, S0, S0}, 8'hFF);
        send_digits(32'h0000_0800, 8);
        put(2'b10, 4'd0, 4'd0);
        wait_idle();
        put(2'b00, 4'd0, 4'd0);
        step(2);
        expect_item(K_SNAP, 1'b1, {{4{BL}}, SE, SR, SR, SO}, 8'hFF);
        wait_idle();
        put(2'b10, 4'd0, 4'd0);
        step(2);
        expect_item(K_SNAP, 1'b1, {{5{BL}}, S8, S0, S0}, 8'hFF);
        wait_idle();
        put(2'b01, 4'd0, 4'd0);
        step(2);
        expect_item(K_SNAP, 1'b1, {{5{BL}}, S8, S0, S0}, 8'hFE);
        wait_idle();
        put(2'b10, 4'd0, 4'd0);
        step(2);
        expect_item(K_FRAME, 1'b0, '0, 8'hFF);
        expect_item(K_FRAME, 1'b1, {{6{BL}}, S7, S7}, 8'hFF);
        send_digits(32'h0000_0123, 8);
        send_digits(32'h0000_0077, 8);
        put(2'b10, 4'd0, 4'd0);
        wait_idle();
        send_digits(32'h0000_0555, 3);
        bus.status = 2'b11;
        bus.pos    = 4'd4;
        bus.data   = 4'd5;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        put(2'b10, 4'd0, 4'd0);
        step(2);
        expect_item(K_SNAP, 1'b1, {{7{BL}}, S0}, 8'hFF);
        wait_idle();
        expect_item(K_FRAME, 1'b1, {{6{BL}}, S5, S6}, 8'hFF);
        send_digits(32'h0000_0056, 8);
        put(2'b10, 4'd0, 4'd0);
        wait_idle();
        step(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
